// File: rtl/i2s_pkg.sv
// Shared widths and state encoding for the I2S tone sequencer.
package i2s_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;
    localparam int PHASE_W = 16;
    localparam int DUR_W   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        FETCH    = 2'd2,
        CAPTURE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/i2s_tone_sequencer_if.sv
// Control, ROM and serializer signals of the tone sequencer.
// master: the sequencer itself. slave: host, ROM and serializer side.
interface i2s_tone_sequencer_if import i2s_pkg::*; ();

    logic                start;
    logic                stop;
    logic [PHASE_W-1:0]  phase_inc;
    logic [DUR_W-1:0]    note_len;
    logic                sample_req;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_q;
    logic [DATA_W-1:0]   sample_data;
    logic                sample_valid;
    logic                busy;
    logic                done;
    logic                overrun;

    modport master (
        input  start, stop, phase_inc, note_len, sample_req, rom_q,
        output rom_addr, sample_data, sample_valid, busy, done, overrun
    );

    modport slave (
        output start, stop, phase_inc, note_len, sample_req, rom_q,
        input  rom_addr, sample_data, sample_valid, busy, done, overrun
    );

endinterface

// File: rtl/i2s_phase_acc.sv
// Phase accumulator: holds the latched increment and the running phase.
// The ROM address is the top ADDR_W bits of the phase, so it wraps naturally.
module i2s_phase_acc import i2s_pkg::*; (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic               step,
    input  logic [PHASE_W-1:0] inc,
    output logic [ADDR_W-1:0]  addr
);

    logic [PHASE_W-1:0] acc_reg;
    logic [PHASE_W-1:0] inc_reg;

    // Clear has priority over step so a restart always begins at phase 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_reg <= '0;
            inc_reg <= '0;
        end else begin
            if (load) begin
                inc_reg <= inc;
            end
            if (clear) begin
                acc_reg <= '0;
            end else if (step) begin
                acc_reg <= acc_reg + inc_reg;
            end
        end
    end

    assign addr = acc_reg[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/i2s_tone_sequencer.sv
// Tone sequencer: on each serializer request fetches one ROM word through
// a registered-address ROM, presents it as the next sample and advances
// the phase accumulator. Notes are finite (note_len samples) or continuous.
module i2s_tone_sequencer import i2s_pkg::*; (
    input  logic                  clk,
    input  logic                  reset_n,
    i2s_tone_sequencer_if.master  bus
);

    localparam logic [DUR_W-1:0] CNT_ONE = DUR_W'(1);

    seq_state_t         state_reg;
    logic [DUR_W-1:0]   cnt_reg;
    logic [DUR_W-1:0]   len_reg;
    logic [DATA_W-1:0]  sample_data_reg;
    logic               sample_valid_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               overrun_reg;

    logic               restart;
    logic               acc_step;
    logic               last_sample;

    // Stop beats start; the accumulator only moves on a real capture.
    assign restart     = bus.start && !bus.stop;
    assign acc_step    = !bus.stop && !bus.start && (state_reg == CAPTURE);
    assign last_sample = (len_reg != '0) && (cnt_reg == len_reg - CNT_ONE);

    i2s_phase_acc u_phase_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (restart),
        .load    (restart),
        .step    (acc_step),
        .inc     (bus.phase_inc),
        .addr    (bus.rom_addr)
    );

    // Sequencer FSM with registered outputs; stop, then start, override the state flow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            len_reg          <= '0;
            sample_data_reg  <= '0;
            sample_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
            if (bus.stop) begin
                state_reg       <= IDLE;
                sample_data_reg <= '0;
                busy_reg        <= 1'b0;
            end else if (bus.start) begin
                state_reg   <= WAIT_REQ;
                cnt_reg     <= '0;
                len_reg     <= bus.note_len;
                overrun_reg <= 1'b0;
                busy_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    WAIT_REQ: begin
                        if (bus.sample_req) begin
                            state_reg <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (bus.sample_req) begin
                            overrun_reg <= 1'b1;
                        end
                        state_reg <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (bus.sample_req) begin
                            overrun_reg <= 1'b1;
                        end
                        sample_data_reg  <= bus.rom_q;
                        sample_valid_reg <= 1'b1;
                        cnt_reg          <= cnt_reg + CNT_ONE;
                        if (last_sample) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= WAIT_REQ;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sample_data  = sample_data_reg;
    assign bus.sample_valid = sample_valid_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_i2s_tone_sequencer.sv
// Self-checking bench for i2s_tone_sequencer: a scoreboard of expected
// samples is filled when requests are driven and drained as sample_valid
// pulses appear.
module tb_i2s_tone_sequencer;

    logic clk;
    logic reset_n;
    int   cyc;
    int   tests;
    int   fails;

    i2s_tone_sequencer_if bus ();

    i2s_tone_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic        done;
        int          due;
    } exp_t;

    exp_t sb[$];

    logic [15:0] acc_m;
    logic [15:0] inc_m;
    logic [15:0] len_m;
    logic [15:0] cnt_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_val(input logic [4:0] a);
        return {a, 3'b101, ~a, 3'b011};
    endfunction

    // Registered-address ROM model
    always @(posedge clk) bus.rom_q <= rom_val(bus.rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.sample_valid) begin
                check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("[TB] sample data=%04h done=%0b cycle=%0d", bus.sample_data, bus.done, cyc);
                    check_eq("sample_data", bus.sample_data, e.data);
                    check_eq("valid_latency", cyc, e.due);
                    check_eq("done", bus.done, e.done);
                end
            end else begin
                check_eq("done_wo_valid", bus.done, 0);
            end
        end
    end

    task automatic do_start(input logic [15:0] inc, input logic [15:0] len);
        bus.start = 1'b1;
        bus.phase_inc = inc;
        bus.note_len = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        acc_m = '0;
        inc_m = inc;
        len_m = len;
        cnt_m = '0;
        $display("[TB] start inc=%04h len=%0d", inc, len);
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
    endtask

    // Drive one request; when push is set the model predicts the sample.
    task automatic do_req(input bit push, input int gap);
        exp_t e;
        if (push) begin
            check_eq("rom_addr", bus.rom_addr, acc_m[15:11]);
            e.data = rom_val(acc_m[15:11]);
            e.done = (len_m != 0) && (cnt_m == len_m - 16'd1);
            e.due  = cyc + 3;
            sb.push_back(e);
            acc_m = acc_m + inc_m;
            cnt_m = cnt_m + 16'd1;
        end
        $display("[TB] req addr=%0d push=%0b cycle=%0d", bus.rom_addr, push, cyc);
        bus.sample_req = 1'b1;
        @(posedge clk); #1;
        bus.sample_req = 1'b0;
        for (int i = 0; i < gap - 1; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        check_eq("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rom_addr"}, bus.rom_addr, 0);
        check_eq({tag, "_sample_data"}, bus.sample_data, 0);
        check_eq({tag, "_sample_valid"}, bus.sample_valid, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_overrun"}, bus.overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.phase_inc = '0;
        bus.note_len = '0;
        bus.sample_req = 1'b0;
        acc_m = '0; inc_m = '0; len_m = '0; cnt_m = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Finite note: 4 samples at one address step each
        do_start(16'h0800, 16'd4);
        check_eq("busy_after_start", bus.busy, 1);
        for (int i = 0; i < 4; i++) do_req(1, 10);
        drain();
        check_eq("busy_after_note", bus.busy, 0);
        check_eq("data_retained", bus.sample_data, rom_val(5'd3));
        do_req(0, 5);
        check_eq("idle_req_no_overrun", bus.overrun, 0);

        // Continuous note with address wrap
        do_start(16'h1000, 16'd0);
        for (int i = 0; i < 20; i++) do_req(1, 5);
        drain();
        check_eq("continuous_busy", bus.busy, 1);
        check_eq("continuous_addr", bus.rom_addr, 8);
        check_eq("no_overrun_yet", bus.overrun, 0);

        // Overrun: second request lands in FETCH
        do_start(16'h0800, 16'd0);
        do_req(1, 1);
        bus.sample_req = 1'b1;
        @(posedge clk); #1;
        bus.sample_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        drain();
        check_eq("overrun_set", bus.overrun, 1);
        do_req(1, 10);
        drain();
        check_eq("overrun_sticky", bus.overrun, 1);
        do_start(16'h0800, 16'd0);
        check_eq("overrun_cleared", bus.overrun, 0);

        // Stop during the capture window
        do_req(1, 10);
        drain();
        do_req(0, 1);
        @(posedge clk); #1;
        do_stop();
        check_eq("stop_sample_data", bus.sample_data, 0);
        check_eq("stop_valid", bus.sample_valid, 0);
        check_eq("stop_busy", bus.busy, 0);
        check_eq("stop_done", bus.done, 0);
        repeat (3) @(posedge clk);
        #1;

        // Start and stop together from IDLE
        bus.start = 1'b1;
        bus.stop = 1'b1;
        bus.phase_inc = 16'h0800;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check_eq("start_stop_busy", bus.busy, 0);
        @(posedge clk); #1;
        check_eq("start_stop_busy2", bus.busy, 0);

        // Restart while busy at address 7
        do_start(16'h0800, 16'd0);
        for (int i = 0; i < 7; i++) do_req(1, 4);
        drain();
        check_eq("addr_before_restart", bus.rom_addr, 7);
        do_start(16'h1000, 16'd0);
        check_eq("restart_busy", bus.busy, 1);
        do_req(1, 4);
        do_req(1, 4);
        drain();
        check_eq("restart_addr", bus.rom_addr, 4);

        // Reset in the middle of a note (during CAPTURE)
        do_req(0, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset_n = 1'b1;
        acc_m = '0; inc_m = '0; len_m = '0; cnt_m = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_reset_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
